// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command issuer: opcode encodings and FSM state type.
package alu_pkg;

    localparam logic [7:0] ALU_ID   = 8'd0;
    localparam logic [7:0] ALU_ADD  = 8'd1;
    localparam logic [7:0] ALU_SUB  = 8'd2;
    localparam logic [7:0] ALU_EQ   = 8'd3;
    localparam logic [7:0] ALU_LE   = 8'd4;
    localparam logic [7:0] ALU_GE   = 8'd5;
    localparam logic [7:0] ALU_NOPS = 8'd6;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_EXEC,
        ST_WB
    } state_t;

endpackage

// File: rtl/alu_regfile.sv
// Register file for the issuer: three combinational read ports, one synchronous
// write port, r0 reads as zero and ignores writes.
module alu_regfile
    import alu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NREG       = 16,
    parameter int unsigned REG_ADDR_W = 4
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  we,
    input  logic [REG_ADDR_W-1:0] waddr,
    input  logic [DATA_WIDTH-1:0] wdata,
    input  logic [REG_ADDR_W-1:0] rs0_addr,
    output logic [DATA_WIDTH-1:0] rs0_data,
    input  logic [REG_ADDR_W-1:0] rs1_addr,
    output logic [DATA_WIDTH-1:0] rs1_data,
    input  logic [REG_ADDR_W-1:0] dbg_addr,
    output logic [DATA_WIDTH-1:0] dbg_data
);

    logic [DATA_WIDTH-1:0] regs [NREG];

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int unsigned i = 0; i < NREG; i++) begin
                regs[i] <= '0;
            end
        end else if (we && (waddr != '0)) begin
            regs[waddr] <= wdata;
        end
    end

    always_comb begin
        rs0_data = (rs0_addr == '0) ? '0 : regs[rs0_addr];
        rs1_data = (rs1_addr == '0) ? '0 : regs[rs1_addr];
        dbg_data = (dbg_addr == '0) ? '0 : regs[dbg_addr];
    end

endmodule

// File: rtl/alu_cmd_issuer.sv
// Initiator side of the ALU interface: reads operands, drives the combinational ALU,
// and writes the masked result back, one command every three cycles.
module alu_cmd_issuer
    import alu_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned NREG       = 16,
    parameter int unsigned REG_ADDR_W = 4
) (
    input  logic                  clk,
    input  logic                  rstn,
    input  logic                  cmd_valid,
    output logic                  cmd_ready,
    input  logic [7:0]            cmd_op,
    input  logic [REG_ADDR_W-1:0] cmd_rd,
    input  logic [REG_ADDR_W-1:0] cmd_rs0,
    input  logic [REG_ADDR_W-1:0] cmd_rs1,
    input  logic                  cmd_imm_en,
    input  logic [DATA_WIDTH-1:0] cmd_imm,
    output logic [7:0]            alu_ctrl,
    output logic [DATA_WIDTH-1:0] alu_in0,
    output logic [DATA_WIDTH-1:0] alu_in1,
    input  logic [DATA_WIDTH-1:0] alu_out,
    output logic                  res_valid,
    output logic [DATA_WIDTH-1:0] res_data,
    output logic [REG_ADDR_W-1:0] res_rd,
    output logic                  op_err,
    input  logic [REG_ADDR_W-1:0] dbg_addr,
    output logic [DATA_WIDTH-1:0] dbg_data
);

    state_t                state, state_nxt;
    logic                  issue, capture, wb;
    logic [7:0]            op_q;
    logic [REG_ADDR_W-1:0] rd_q;
    logic [DATA_WIDTH-1:0] rs0_data, rs1_data, alu_masked;

    alu_regfile #(
        .DATA_WIDTH (DATA_WIDTH),
        .NREG       (NREG),
        .REG_ADDR_W (REG_ADDR_W)
    ) u_regfile (
        .clk      (clk),
        .rstn     (rstn),
        .we       (wb),
        .waddr    (res_rd),
        .wdata    (res_data),
        .rs0_addr (cmd_rs0),
        .rs0_data (rs0_data),
        .rs1_addr (cmd_rs1),
        .rs1_data (rs1_data),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // cmd_ready is gated by rstn so nothing is accepted while reset is held.
    always_comb begin
        state_nxt = state;
        cmd_ready = 1'b0;
        issue     = 1'b0;
        capture   = 1'b0;
        wb        = 1'b0;
        res_valid = 1'b0;
        op_err    = 1'b0;
        case (state)
            ST_IDLE: begin
                cmd_ready = rstn;
                if (cmd_valid && rstn) begin
                    issue     = 1'b1;
                    state_nxt = ST_EXEC;
                end
            end
            ST_EXEC: begin
                capture   = 1'b1;
                state_nxt = ST_WB;
            end
            ST_WB: begin
                wb        = 1'b1;
                res_valid = 1'b1;
                op_err    = (op_q >= ALU_NOPS);
                state_nxt = ST_IDLE;
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    // Compare ops yield a single boolean bit; illegal ops retire a zero result.
    always_comb begin
        alu_masked = '0;
        if (op_q >= ALU_NOPS) begin
            alu_masked = '0;
        end else if (op_q >= ALU_EQ) begin
            alu_masked[0] = alu_out[0];
        end else begin
            alu_masked = alu_out;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            alu_ctrl <= '0;
            alu_in0  <= '0;
            alu_in1  <= '0;
            op_q     <= '0;
            rd_q     <= '0;
            res_data <= '0;
            res_rd   <= '0;
        end else begin
            if (issue) begin
                alu_ctrl <= cmd_op;
                alu_in0  <= rs0_data;
                alu_in1  <= cmd_imm_en ? cmd_imm : rs1_data;
                op_q     <= cmd_op;
                rd_q     <= cmd_rd;
            end
            if (capture) begin
                res_data <= alu_masked;
                res_rd   <= rd_q;
            end
        end
    end

endmodule

// File: tb/tb_alu_cmd_issuer.sv
// Directed self-checking bench for alu_cmd_issuer with a behavioural ALU that
// deliberately drives junk upper bits on compare results.
module tb_alu_cmd_issuer;

    logic        clk = 1'b0;
    logic        rstn;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [7:0]  cmd_op;
    logic [3:0]  cmd_rd, cmd_rs0, cmd_rs1;
    logic        cmd_imm_en;
    logic [31:0] cmd_imm;
    logic [7:0]  alu_ctrl;
    logic [31:0] alu_in0, alu_in1, alu_out;
    logic        res_valid;
    logic [31:0] res_data;
    logic [3:0]  res_rd;
    logic        op_err;
    logic [3:0]  dbg_addr;
    logic [31:0] dbg_data;

    int passed = 0;
    int total  = 0;
    int pulses;

    alu_cmd_issuer #(
        .DATA_WIDTH (32),
        .NREG       (16),
        .REG_ADDR_W (4)
    ) dut (
        .clk        (clk),
        .rstn       (rstn),
        .cmd_valid  (cmd_valid),
        .cmd_ready  (cmd_ready),
        .cmd_op     (cmd_op),
        .cmd_rd     (cmd_rd),
        .cmd_rs0    (cmd_rs0),
        .cmd_rs1    (cmd_rs1),
        .cmd_imm_en (cmd_imm_en),
        .cmd_imm    (cmd_imm),
        .alu_ctrl   (alu_ctrl),
        .alu_in0    (alu_in0),
        .alu_in1    (alu_in1),
        .alu_out    (alu_out),
        .res_valid  (res_valid),
        .res_data   (res_data),
        .res_rd     (res_rd),
        .op_err     (op_err),
        .dbg_addr   (dbg_addr),
        .dbg_data   (dbg_data)
    );

    always #5 clk = ~clk;

    logic [31:0] diff;
    assign diff = alu_in0 - alu_in1;

    always_comb begin
        case (alu_ctrl)
            8'd0:    alu_out = alu_in0;
            8'd1:    alu_out = alu_in0 + alu_in1;
            8'd2:    alu_out = diff;
            8'd3:    alu_out = {31'h5A5A_A5A5, alu_in0 == alu_in1};
            8'd4:    alu_out = {31'h7FFF_FFFF, diff[31] | (diff == 32'd0)};
            8'd5:    alu_out = {31'h1234_5678, ~diff[31]};
            default: alu_out = 32'hDEAD_BEEF;
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    endtask

    task automatic dbg_chk(input string tag, input logic [3:0] addr, input logic [31:0] exp);
        dbg_addr = addr;
        #1;
        chk(tag, dbg_data, exp);
    endtask

    // Called one time unit after a rising edge with the DUT idle.
    task automatic do_cmd(input string tag, input logic [7:0] op, input logic [3:0] rd,
                          input logic [3:0] rs0, input logic [3:0] rs1, input logic ie,
                          input logic [31:0] imm, input logic [31:0] e_in0,
                          input logic [31:0] e_in1, input logic [31:0] e_res,
                          input logic e_err);
        cmd_valid = 1'b1; cmd_op = op; cmd_rd = rd; cmd_rs0 = rs0; cmd_rs1 = rs1;
        cmd_imm_en = ie; cmd_imm = imm;
        chk({tag, ".ready"}, 32'(cmd_ready), 32'd1);
        @(posedge clk); #1;
        cmd_valid = 1'b0; cmd_op = 8'hAA; cmd_rd = 4'hF; cmd_rs0 = 4'hE; cmd_rs1 = 4'hD;
        cmd_imm_en = ~ie; cmd_imm = 32'hCAFE_F00D;
        chk({tag, ".ctrl"},     32'(alu_ctrl),  32'(op));
        chk({tag, ".in0"},      alu_in0,        e_in0);
        chk({tag, ".in1"},      alu_in1,        e_in1);
        chk({tag, ".exec_rdy"}, 32'(cmd_ready), 32'd0);
        chk({tag, ".exec_vld"}, 32'(res_valid), 32'd0);
        @(posedge clk); #1;
        chk({tag, ".res_valid"}, 32'(res_valid), 32'd1);
        chk({tag, ".res_data"},  res_data,       e_res);
        chk({tag, ".res_rd"},    32'(res_rd),    32'(rd));
        chk({tag, ".op_err"},    32'(op_err),    32'(e_err));
        chk({tag, ".wb_rdy"},    32'(cmd_ready), 32'd0);
        @(posedge clk); #1;
        chk({tag, ".post_vld"}, 32'(res_valid), 32'd0);
        chk({tag, ".post_err"}, 32'(op_err),    32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not reach its end (%0d/%0d checks passed so far)", passed, total);
        $fatal(1, "watchdog expired");
    end

    initial begin
        rstn = 1'b0; cmd_valid = 1'b0; cmd_op = '0; cmd_rd = '0; cmd_rs0 = '0;
        cmd_rs1 = '0; cmd_imm_en = 1'b0; cmd_imm = '0; dbg_addr = '0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        chk("rst.ready",    32'(cmd_ready), 32'd0);
        chk("rst.valid",    32'(res_valid), 32'd0);
        chk("rst.err",      32'(op_err),    32'd0);
        chk("rst.ctrl",     32'(alu_ctrl),  32'd0);
        chk("rst.in0",      alu_in0,        32'd0);
        chk("rst.in1",      alu_in1,        32'd0);
        chk("rst.res_data", res_data,       32'd0);
        chk("rst.res_rd",   32'(res_rd),    32'd0);
        rstn = 1'b1;
        @(posedge clk); #1;
        chk("rel.ready", 32'(cmd_ready), 32'd1);

        // Load operands and add
        do_cmd("ld_r1", 8'd1, 4'd1, 4'd0, 4'd0, 1'b1, 32'd5, 32'd0, 32'd5, 32'd5, 1'b0);
        do_cmd("ld_r2", 8'd1, 4'd2, 4'd0, 4'd0, 1'b1, 32'd7, 32'd0, 32'd7, 32'd7, 1'b0);
        do_cmd("add",   8'd1, 4'd3, 4'd1, 4'd2, 1'b0, 32'd0, 32'd5, 32'd7, 32'd12, 1'b0);
        dbg_chk("dbg_r3_add", 4'd3, 32'd12);

        // Subtract wrap, le, ge
        do_cmd("ld_r1_0", 8'd1, 4'd1, 4'd0, 4'd0, 1'b1, 32'd0, 32'd0, 32'd0, 32'd0, 1'b0);
        do_cmd("sub",     8'd2, 4'd4, 4'd1, 4'd0, 1'b1, 32'd1, 32'd0, 32'd1, 32'hFFFF_FFFF, 1'b0);
        dbg_chk("dbg_r4_sub", 4'd4, 32'hFFFF_FFFF);
        do_cmd("ld_r1_3", 8'd1, 4'd1, 4'd0, 4'd0, 1'b1, 32'd3, 32'd0, 32'd3, 32'd3, 1'b0);
        do_cmd("ld_r2_9", 8'd1, 4'd2, 4'd0, 4'd0, 1'b1, 32'd9, 32'd0, 32'd9, 32'd9, 1'b0);
        do_cmd("le",      8'd4, 4'd5, 4'd1, 4'd2, 1'b0, 32'd0, 32'd3, 32'd9, 32'd1, 1'b0);
        do_cmd("ge",      8'd5, 4'd6, 4'd1, 4'd2, 1'b0, 32'd0, 32'd3, 32'd9, 32'd0, 1'b0);

        // Compare masking: ALU returns junk upper bits
        do_cmd("eq", 8'd3, 4'd7, 4'd1, 4'd1, 1'b0, 32'd0, 32'd3, 32'd3, 32'd1, 1'b0);
        dbg_chk("dbg_r7_eq", 4'd7, 32'd1);

        // r0 write dropped; illegal op zeroes the destination
        do_cmd("r0_wr", 8'd1, 4'd0, 4'd0, 4'd0, 1'b1, 32'd5, 32'd0, 32'd5, 32'd5, 1'b0);
        dbg_chk("dbg_r0", 4'd0, 32'd0);
        do_cmd("illegal", 8'd9, 4'd3, 4'd3, 4'd0, 1'b1, 32'd1, 32'd12, 32'd1, 32'd0, 1'b1);
        dbg_chk("dbg_r3_ill", 4'd3, 32'd0);

        // Back-to-back: valid held high for three commands
        pulses = 0;
        cmd_valid = 1'b1; cmd_op = 8'd1; cmd_rs0 = 4'd0; cmd_rs1 = 4'd0; cmd_imm_en = 1'b1;
        for (int t = 0; t < 9; t++) begin
            chk($sformatf("bp.ready%0d", t), 32'(cmd_ready), 32'((t % 3) == 0));
            chk($sformatf("bp.valid%0d", t), 32'(res_valid), 32'((t % 3) == 2));
            if (res_valid) begin
                pulses++;
                chk($sformatf("bp.data%0d", t), res_data, 32'(10 + t / 3));
            end
            if ((t % 3) == 0) begin
                cmd_rd  = 4'(9 + t / 3);
                cmd_imm = 32'(10 + t / 3);
            end
            @(posedge clk); #1;
        end
        cmd_valid = 1'b0;
        chk("bp.pulses", 32'(pulses), 32'd3);
        dbg_chk("bp.r9",  4'd9,  32'd10);
        dbg_chk("bp.r10", 4'd10, 32'd11);
        dbg_chk("bp.r11", 4'd11, 32'd12);

        // Reset while in EXEC
        cmd_valid = 1'b1; cmd_op = 8'd1; cmd_rd = 4'd12; cmd_rs0 = 4'd0;
        cmd_imm_en = 1'b1; cmd_imm = 32'h77;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        chk("mid.exec_in1", alu_in1, 32'h77);
        #1;
        rstn = 1'b0;
        #1;
        chk("mid.ready",    32'(cmd_ready), 32'd0);
        chk("mid.valid",    32'(res_valid), 32'd0);
        chk("mid.ctrl",     32'(alu_ctrl),  32'd0);
        chk("mid.in1",      alu_in1,        32'd0);
        chk("mid.res_data", res_data,       32'd0);
        chk("mid.res_rd",   32'(res_rd),    32'd0);
        dbg_chk("mid.r12", 4'd12, 32'd0);
        dbg_chk("mid.r9",  4'd9,  32'd0);
        @(posedge clk); #1;
        chk("mid.hold_valid", 32'(res_valid), 32'd0);
        rstn = 1'b1;
        @(posedge clk); #1;
        chk("mid.rel_ready", 32'(cmd_ready), 32'd1);
        chk("mid.rel_valid", 32'(res_valid), 32'd0);
        @(posedge clk); #1;
        chk("mid.late_valid", 32'(res_valid), 32'd0);
        dbg_chk("mid.r12_after", 4'd12, 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/alu_cmd_issuer.md
Name: alu_cmd_issuer

Overview:
- Initiator side of the ALU interface: accepts commands over a valid/ready handshake and owns a small register file.
- Reads each command's operands and drives the ALU ctrl/in0/in1 inputs.
- Captures the ALU result and writes it back to the register file.
- Sits between the processor command path and the combinational ALU; one command in flight at a time.

Parameters:
- DATA_WIDTH, 32, width of ALU operands/result and register-file entries
- NREG, 16, number of registers; r0 is hardwired to zero
- REG_ADDR_W, 4, register address width, equal to clog2(NREG)

Ports:
- clk  in  1  single clock
- rstn  in  1  asynchronous active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  issuer can accept a command
- cmd_op  in  8  ALU opcode (0 id, 1 add, 2 sub, 3 eq, 4 le, 5 ge)
- cmd_rd  in  REG_ADDR_W  destination register
- cmd_rs0  in  REG_ADDR_W  source register for in0
- cmd_rs1  in  REG_ADDR_W  source register for in1
- cmd_imm_en  in  1  1 = in1 taken from cmd_imm instead of rs1
- cmd_imm  in  DATA_WIDTH  immediate operand
- alu_ctrl  out  8  opcode to the ALU
- alu_in0  out  DATA_WIDTH  ALU operand 0
- alu_in1  out  DATA_WIDTH  ALU operand 1
- alu_out  in  DATA_WIDTH  ALU result (combinational from alu_*)
- res_valid  out  1  one-cycle pulse: writeback performed
- res_data  out  DATA_WIDTH  value written on the res_valid cycle
- res_rd  out  REG_ADDR_W  destination register of the res_valid cycle
- op_err  out  1  one-cycle pulse: illegal opcode retired
- dbg_addr  in  REG_ADDR_W  debug read address
- dbg_data  out  DATA_WIDTH  combinational read of register dbg_addr

Behaviour:
- Reset (rstn low, async):
  - State goes to IDLE.
  - All registers, alu_ctrl, alu_in0, alu_in1, res_data and res_rd go to 0.
  - res_valid and op_err go to 0; cmd_ready goes to 0 while rstn is low.
- Reset mid-command: the command is discarded with no writeback. cmd_ready is 1 on the first clk edge after release.
- FSM states: IDLE, EXEC, WB.
  - IDLE: cmd_ready = 1. On cmd_valid & cmd_ready (cycle 0):
    - alu_ctrl <= cmd_op.
    - alu_in0 <= reg[cmd_rs0].
    - alu_in1 <= cmd_imm_en ? cmd_imm : reg[cmd_rs1].
    - Latch rd and op; go to EXEC.
  - EXEC (cycle 1): alu_* are stable and alu_out is valid this cycle.
    - res_data <= masked alu_out; res_rd <= rd; go to WB.
    - Masking rule: ops 3-5 keep bit 0 and force bits DATA_WIDTH-1:1 to 0. Ops 0-2 pass the full word. Ops > 5 give 0.
  - WB (cycle 2): res_valid = 1; reg[rd] <= res_data unless rd == 0.
    - op_err = 1 if the latched op > 5.
    - Go to IDLE.
- Throughput: one command per 3 cycles. cmd_ready is low in EXEC and WB.
- cmd_* fields are sampled only on the handshake cycle; changes while not ready are ignored.
- No hazard logic is needed: the next command is read in IDLE, after the WB write has completed.
- Arithmetic: add/sub wrap modulo 2^DATA_WIDTH with no carry out. le/ge use the sign bit of in0-in1 as computed by the ALU.
- r0: writes are dropped, reads return 0. res_valid still pulses, with res_rd = 0.
- alu_* hold their last value in IDLE; they are not cleared between commands.
- dbg_data is combinational and reflects a WB write from the cycle after the WB edge.

Decomposition:
- Shared package alu_pkg:
  - Opcode constants ALU_ID=0, ALU_ADD=1, ALU_SUB=2, ALU_EQ=3, ALU_LE=4, ALU_GE=5, ALU_NOPS=6.
  - FSM state typedef.
- Sub-module alu_regfile:
  - NREG x DATA_WIDTH, async active-low reset.
  - 3 combinational read ports (rs0, rs1, dbg) and 1 synchronous write port.
  - r0 hardwired to zero.

Test Plan:
- Reset then add: write r1=5 and r2=7 via op 0 imm (rs0 = r0 gives 0, so use op 1 with rs0=r0, imm). Then op=1, rd=3, rs0=1, rs1=2 -> alu_ctrl=1, in0=5, in1=7 one cycle after the handshake; res_valid with res_data=12, res_rd=3 two cycles after; dbg r3=12.
- Sub wrap: r1=0, imm=1, op=2 -> res_data=0xFFFFFFFF. Then op=4 (le) with r1=3, r2=9 -> res_data=1 with upper bits 0. op=5 -> res_data=0.
- Compare masking: the ALU model drives garbage upper bits on op 3 with equal operands -> res_data=0x00000001.
- r0 write and illegal op: op=1, rd=0, imm=5 -> res_valid pulses, dbg r0 stays 0. op=9 -> res_data=0, op_err pulses 1 cycle with res_valid.
- Backpressure: cmd_valid held high for 3 commands -> cmd_ready pattern 1,0,0 repeating; exactly 3 res_valid pulses at cycles 2, 5, 8.
- Reset mid-op: assert rstn low in EXEC -> no res_valid, destination unchanged (0), all outputs 0; cmd_ready=1 on the first edge after release.
